// File: rtl/imem_arbiter.sv
// Shares one RAM port between instruction fetch and the memory stage, one access at a time.
// Define IMEM_ARB_RR_EN for round-robin arbitration; otherwise MEM has fixed priority.
module imem_arbiter #(
  parameter int AW      = 6,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          IfReq,
  input  logic [31:0]   IfAddr,
  input  logic          IfKill,
  output logic          IfValid,
  output logic [31:0]   IfRdata,
  output logic          IfStall,
  input  logic          MemReq,
  input  logic          MemWe,
  input  logic [31:0]   MemAddr,
  input  logic [31:0]   MemWdata,
  output logic          MemValid,
  output logic [31:0]   MemRdata,
  output logic          MemStall,
  output logic          RamReq,
  output logic          RamWe,
  output logic [AW-1:0] RamAddr,
  output logic [31:0]   RamWdata,
  input  logic [31:0]   RamRdata,
  input  logic          RamAck,
  output logic          TimeoutErr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BUSY_IF        = 2'd1,
    BUSY_IF_KILLED = 2'd2,
    BUSY_MEM       = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic          mem_elig, if_elig;
  logic          grant_mem, grant_if;
  logic          busy, if_done, mem_done;
  logic [CW-1:0] cnt;

  // A requester raising Req during its own Valid cycle is dropping it, not asking again.
  assign mem_elig = MemReq && !MemValid;
  assign if_elig  = IfReq && !IfValid && !IfKill;

`ifdef IMEM_ARB_RR_EN
  logic last_mem;

  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    if (state == IDLE) begin
      grant_mem = mem_elig && (!if_elig || !last_mem);
      grant_if  = if_elig && !grant_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          last_mem <= 1'b0;
    else if (grant_mem) last_mem <= 1'b1;
    else if (grant_if)  last_mem <= 1'b0;
  end
`else
  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    if (state == IDLE) begin
      grant_mem = mem_elig;
      grant_if  = if_elig && !mem_elig;
    end
  end
`endif

  assign busy     = (state != IDLE);
  assign if_done  = (state == BUSY_IF) && RamAck && !IfKill;
  assign mem_done = (state == BUSY_MEM) && RamAck;

  assign RamReq   = busy;
  assign IfStall  = IfReq && !IfValid;
  assign MemStall = MemReq && !MemValid;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_mem)     state_nx = BUSY_MEM;
        else if (grant_if) state_nx = BUSY_IF;
      end
      BUSY_IF: begin
        if (RamAck)      state_nx = IDLE;
        else if (IfKill) state_nx = BUSY_IF_KILLED;
      end
      BUSY_IF_KILLED: if (RamAck) state_nx = IDLE;
      BUSY_MEM:       if (RamAck) state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      IfValid    <= 1'b0;
      IfRdata    <= '0;
      MemValid   <= 1'b0;
      MemRdata   <= '0;
      RamWe      <= 1'b0;
      RamAddr    <= '0;
      RamWdata   <= '0;
      TimeoutErr <= 1'b0;
      cnt        <= '0;
    end else begin
      state    <= state_nx;
      IfValid  <= if_done;
      MemValid <= mem_done;
      if (if_done)              IfRdata  <= RamRdata;
      if (mem_done && !RamWe)   MemRdata <= RamRdata;
      if (grant_mem) begin
        RamAddr  <= MemAddr[AW+1:2];
        RamWe    <= MemWe;
        RamWdata <= MemWdata;
      end else if (grant_if) begin
        RamAddr  <= IfAddr[AW+1:2];
        RamWe    <= 1'b0;
        RamWdata <= '0;
      end
      // Saturating wait counter; the flag fires on the step that reaches TIMEOUT.
      if (grant_mem || grant_if) begin
        cnt <= '0;
      end else if (busy && !RamAck && cnt != CW'(TIMEOUT)) begin
        cnt <= cnt + CW'(1);
        if (cnt == CW'(TIMEOUT - 1)) TimeoutErr <= 1'b1;
      end
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{IfAddr[31:AW+2], IfAddr[1:0], MemAddr[31:AW+2], MemAddr[1:0]};

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed scenarios plus randomized traffic checked against a word-array memory model.
module tb_imem_arbiter;

  localparam int AW = 6;
`ifdef IMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk, reset;
  logic          IfReq, IfKill, IfValid, IfStall;
  logic [31:0]   IfAddr, IfRdata;
  logic          MemReq, MemWe, MemValid, MemStall;
  logic [31:0]   MemAddr, MemWdata, MemRdata;
  logic          RamReq, RamWe, RamAck;
  logic [AW-1:0] RamAddr;
  logic [31:0]   RamWdata, RamRdata;
  logic          TimeoutErr;

  imem_arbiter #(.AW(AW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfKill(IfKill), .IfValid(IfValid),
    .IfRdata(IfRdata), .IfStall(IfStall),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemValid(MemValid), .MemRdata(MemRdata), .MemStall(MemStall),
    .RamReq(RamReq), .RamWe(RamWe), .RamAddr(RamAddr), .RamWdata(RamWdata),
    .RamRdata(RamRdata), .RamAck(RamAck), .TimeoutErr(TimeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM behaviour: word array, optional read-data override, manual or random ack.
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  logic        ram_init, ovr_en, manual_ack, auto_en, rand_ack;
  logic [31:0] ovr;
  int          n_chk, n_err;
  logic [31:0] last_mrd;

  function automatic logic [31:0] pat(input int i);
    return 32'h9E37_79B9 * (i + 1);
  endfunction

  function automatic int w(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  function automatic logic [31:0] raddr();
    logic [31:0] r;
    r = $urandom;
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
    end else if (RamReq && RamAck && RamWe) begin
      mem[RamAddr] <= RamWdata;
    end
  end

  always @(negedge clk) rand_ack <= ($urandom_range(3) != 0);

  assign RamRdata = ovr_en ? ovr : mem[RamAddr];
  assign RamAck   = manual_ack | (auto_en & rand_ack);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input bit init);
    IfReq = 0; IfKill = 0; IfAddr = 0;
    MemReq = 0; MemWe = 0; MemAddr = 0; MemWdata = 0;
    manual_ack = 0; auto_en = 0; ovr_en = 0;
    reset = 1; ram_init = init;
    nxt();
    ram_init = 0;
    nxt();
    reset = 0;
    last_mrd = 0;
  endtask

  initial begin
    int if_wait, mem_wait, n_if, n_mem;
    bit hung;
    n_chk = 0; n_err = 0; ovr = 0; rand_ack = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);

    // Reset state
    do_reset(1);
    check("rst_ramreq", RamReq, 0);
    check("rst_ramaddr", RamAddr, 0);
    check("rst_valids", {IfValid, MemValid, TimeoutErr, RamWe}, 0);

    // Single fetch, ack held high
    ovr_en = 1; ovr = 32'hDEADBEEF; manual_ack = 1;
    IfReq = 1; IfAddr = 32'h10;
    #1;
    check("f_stall0", IfStall, 1);
    check("f_ramreq0", RamReq, 0);
    nxt();
    check("f_ramreq1", RamReq, 1);
    check("f_addr1", RamAddr, 4);
    check("f_we1", RamWe, 0);
    check("f_stall1", IfStall, 1);
    nxt();
    check("f_valid2", IfValid, 1);
    check("f_data2", IfRdata, 32'hDEADBEEF);
    check("f_stall2", IfStall, 0);
    nxt();
    check("f_noregrant", RamReq, 0);
    check("f_valid3", IfValid, 0);
    IfReq = 0; ovr_en = 0; manual_ack = 0;
    nxt();

    // Collision: MEM load wins first, IF granted in the MemValid cycle
    IfReq = 1; IfAddr = 32'h40; MemReq = 1; MemWe = 0; MemAddr = 32'h20;
    nxt();
    check("c1_addr", RamAddr, 8);
    check("c1_ifstall", IfStall, 1);
    nxt(); nxt(); nxt();
    manual_ack = 1;
    nxt();
    check("c1_memvalid", MemValid, 1);
    check("c1_memdata", MemRdata, ref_mem[8]);
    last_mrd = ref_mem[8];
    MemReq = 0; manual_ack = 0;
    nxt();
    check("c1_memvalid_once", MemValid, 0);
    check("c1_if_granted", RamReq, 1);
    check("c1_if_addr", RamAddr, 16);
    manual_ack = 1;
    nxt();
    check("c1_ifvalid", IfValid, 1);
    check("c1_ifdata", IfRdata, ref_mem[16]);
    IfReq = 0; manual_ack = 0;
    nxt();

    // Store: address/data held until ack, MemRdata untouched
    MemReq = 1; MemWe = 1; MemAddr = 32'h3C; MemWdata = 32'h12345678;
    nxt();
    check("s_ramreq", RamReq, 1);
    check("s_we", RamWe, 1);
    check("s_addr", RamAddr, 15);
    check("s_wdata", RamWdata, 32'h12345678);
    nxt();
    check("s_addr_hold", RamAddr, 15);
    check("s_wdata_hold", RamWdata, 32'h12345678);
    manual_ack = 1;
    nxt();
    check("s_valid", MemValid, 1);
    check("s_rdata_kept", MemRdata, last_mrd);
    ref_mem[15] = 32'h12345678;
    MemReq = 0; MemWe = 0; manual_ack = 0;
    nxt();

    // Second collision: round-robin favours IF after a MEM grant
    manual_ack = 1;
    IfReq = 1; IfAddr = 32'h44; MemReq = 1; MemAddr = 32'h24;
    nxt();
    check("c2_first_addr", RamAddr, RR ? 17 : 9);
    nxt();
    check("c2_first_valid", RR ? IfValid : MemValid, 1);
    check("c2_first_data", RR ? IfRdata : MemRdata, RR ? ref_mem[17] : ref_mem[9]);
    if (RR) IfReq = 0; else begin MemReq = 0; last_mrd = ref_mem[9]; end
    nxt();
    check("c2_second_addr", RamAddr, RR ? 9 : 17);
    nxt();
    check("c2_second_valid", RR ? MemValid : IfValid, 1);
    check("c2_second_data", RR ? MemRdata : IfRdata, RR ? ref_mem[9] : ref_mem[17]);
    if (RR) last_mrd = ref_mem[9];
    IfReq = 0; MemReq = 0; manual_ack = 0;
    nxt();

    // Kill an in-flight fetch and redirect to the stored word
    IfReq = 1; IfAddr = 32'h08;
    nxt();
    check("k_ramreq", RamReq, 1);
    IfKill = 1; IfAddr = 32'h3C;
    nxt();
    IfKill = 0;
    check("k_still_busy", RamReq, 1);
    check("k_addr_held", RamAddr, 2);
    nxt();
    manual_ack = 1;
    nxt();
    check("k_no_valid", IfValid, 0);
    check("k_idle", RamReq, 0);
    nxt();
    check("k_regrant_addr", RamAddr, 15);
    nxt();
    check("k_new_valid", IfValid, 1);
    check("k_new_data", IfRdata, 32'h12345678);
    IfReq = 0; manual_ack = 0;
    nxt();

    // Timeout: flag set exactly 16 busy cycles after RamReq rises
    IfReq = 1; IfAddr = 32'h0C;
    nxt();
    check("t_ramreq", RamReq, 1);
    for (int k = 0; k < 15; k++) nxt();
    check("t_not_yet", TimeoutErr, 0);
    nxt();
    check("t_set", TimeoutErr, 1);
    for (int k = 0; k < 5; k++) nxt();
    check("t_sticky", TimeoutErr, 1);
    check("t_waiting", RamReq, 1);
    manual_ack = 1;
    nxt();
    check("t_late_valid", IfValid, 1);
    check("t_late_data", IfRdata, ref_mem[3]);
    IfReq = 0; manual_ack = 0;
    nxt();
    check("t_sticky_idle", TimeoutErr, 1);

    // Reset in the middle of a MEM access
    MemReq = 1; MemWe = 0; MemAddr = 32'h30;
    nxt();
    check("r_busy", RamReq, 1);
    reset = 1;
    nxt();
    reset = 0; MemReq = 0; manual_ack = 1;
    check("r_ramreq", RamReq, 0);
    check("r_ramaddr", RamAddr, 0);
    check("r_flags", {IfValid, MemValid, TimeoutErr, RamWe}, 0);
    check("r_rdata", IfRdata | MemRdata | RamWdata, 0);
    nxt();
    check("r_late_ack", MemValid, 0);
    nxt();
    check("r_late_ack2", {MemValid, RamReq}, 0);
    manual_ack = 0;

    // Randomized traffic against the memory model
    do_reset(0);
    auto_en = 1;
    if_wait = 0; mem_wait = 0; n_if = 0; n_mem = 0; hung = 0;
    for (int cyc = 0; cyc < 4000 && !hung; cyc++) begin
      nxt();
      check("rnd_ifstall", IfStall, IfReq && !IfValid);
      check("rnd_memstall", MemStall, MemReq && !MemValid);
      if (IfValid) begin
        check("rnd_if_req", IfReq, 1);
        check("rnd_if_data", IfRdata, ref_mem[w(IfAddr)]);
        IfReq = 0; if_wait = 0; n_if++;
      end
      if (MemValid) begin
        check("rnd_mem_req", MemReq, 1);
        if (MemWe) begin
          ref_mem[w(MemAddr)] = MemWdata;
          check("rnd_st_rdata", MemRdata, last_mrd);
        end else begin
          check("rnd_ld_data", MemRdata, ref_mem[w(MemAddr)]);
          last_mrd = ref_mem[w(MemAddr)];
        end
        MemReq = 0; mem_wait = 0; n_mem++;
      end
      IfKill = 0;
      if (IfReq) begin
        if_wait++;
        if ($urandom_range(15) == 0) begin IfKill = 1; IfAddr = raddr(); end
      end else if ($urandom_range(1) == 1) begin
        IfReq = 1; IfAddr = raddr();
      end
      if (MemReq) mem_wait++;
      else if ($urandom_range(1) == 1) begin
        MemReq = 1; MemWe = $urandom_range(1) == 1; MemAddr = raddr(); MemWdata = raddr();
      end
      if (if_wait > 200 || mem_wait > 200) begin
        check("rnd_hang", if_wait > 200 || mem_wait > 200, 0);
        hung = 1;
      end
    end
    check("rnd_if_progress", n_if > 100, 1);
    check("rnd_mem_progress", n_mem > 100, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Single-outstanding arbiter that shares one word-wide instruction/data RAM port between the fetch stage (IF) and the memory stage (MEM).
- Sequences each access with a req/ack handshake to the RAM and returns registered read data.
- Produces per-requester stall signals for the pipeline hazard logic.
- Discards in-flight fetches that are killed by a jump or branch redirect.

Parameters:
- AW, 6, RAM word-address width; the RAM address is taken from bits [AW+1:2] of the byte address.
- TIMEOUT, 16, number of cycles in a busy state without ack before the error flag is set; minimum 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- IfReq  in  1  fetch read request, held until IfValid
- IfAddr  in  32  fetch byte address, stable while IfReq
- IfKill  in  1  redirect: discard any pending fetch
- IfValid  out  1  one-cycle pulse, IfRdata valid
- IfRdata  out  32  fetched instruction word
- IfStall  out  1  IfReq && !IfValid
- MemReq  in  1  load/store request, held until MemValid
- MemWe  in  1  1 = store, 0 = load
- MemAddr  in  32  load/store byte address
- MemWdata  in  32  store data
- MemValid  out  1  one-cycle completion pulse, for loads and stores
- MemRdata  out  32  load data; unchanged on a store
- MemStall  out  1  MemReq && !MemValid
- RamReq  out  1  RAM access request
- RamWe  out  1  RAM write enable
- RamAddr  out  AW  RAM word address
- RamWdata  out  32  RAM write data
- RamRdata  in  32  RAM read data, sampled on ack
- RamAck  in  1  access complete when RamReq && RamAck
- TimeoutErr  out  1  sticky timeout flag

Behaviour:
- States: IDLE, BUSY_IF, BUSY_IF_KILLED, BUSY_MEM; 2-bit state register.
- Reset (sync) clears every output and RamAddr/RamWdata to 0 and returns the state to IDLE.
  - An in-flight transaction is abandoned on reset.
  - A late RamAck arriving after reset is ignored, because RamReq is 0.
- Arbitration in IDLE:
  - A requester's Req is ignored in the cycle its own Valid is high, because the requester is dropping it that cycle.
  - An eligible MemReq goes to BUSY_MEM.
  - Otherwise an eligible IfReq && !IfKill goes to BUSY_IF.
  - Otherwise the block stays in IDLE.
  - MEM has fixed priority, unless the optional feature below is enabled.
- Grant latency:
  - At the grant edge, RamAddr, RamWe and RamWdata are latched from the winner.
  - RamReq = (state != IDLE), so RamReq rises the cycle after the request is first seen.
  - RamAddr, RamWe and RamWdata are held constant until the ack.
  - RamWe is 0 for fetches.
- Completion: in a busy state with RamAck=1, at the next edge:
  - From BUSY_MEM, set MemValid=1; load MemRdata = RamRdata if !RamWe.
  - From BUSY_IF, set IfValid=1 and IfRdata = RamRdata.
  - From BUSY_IF_KILLED, emit no IfValid; the data is dropped.
  - All cases return to IDLE.
  - Valid is high exactly one cycle.
  - Minimum request-to-Valid latency is 2 cycles, with RamAck held at 1.
- Kill:
  - IfKill in BUSY_IF without RamAck moves to BUSY_IF_KILLED.
  - IfKill with RamAck in the same cycle suppresses IfValid and returns to IDLE.
  - IfKill in IDLE blocks a fetch grant that cycle.
  - IfKill has no effect on MEM.
- Back-to-back: the cycle a Valid pulses, the state is IDLE and the other requester may be granted. The same requester's next access starts one cycle later at the earliest.
- Timeout:
  - A counter clears on every grant and increments each busy cycle without ack.
  - When it reaches TIMEOUT, TimeoutErr is set and stays set until reset. The transaction keeps waiting.
  - The counter saturates and does not wrap.
- Stalls are combinational from Req and the registered Valid. MemStall does not depend on IF.

Optional Feature:
- IMEM_ARB_RR_EN defined: round-robin arbitration with a 1-bit last-granted register, reset to IF.
  - When both requests are eligible in IDLE, the requester not granted last wins.
  - A single eligible requester always wins.
- IMEM_ARB_RR_EN undefined: fixed MEM priority; no last-granted register exists.

Test Plan:
- Fetch, single: IfReq=1, IfAddr=0x0000_0010, ack held at 1 with RamRdata=0xDEAD_BEEF -> RamReq=1 and RamAddr=4 at cycle 1; IfValid=1 and IfRdata=0xDEADBEEF at cycle 2; IfStall high for cycles 0-1.
- Collision: IfReq and MemReq (load, addr 0x20) in the same cycle, ack 3 cycles after RamReq -> MEM is served first (RamAddr=8), MemValid pulses; IF is granted in that Valid cycle. With IMEM_ARB_RR_EN, a second collision grants IF first.
- Kill: fetch in BUSY_IF, IfKill pulsed one cycle, ack 2 cycles later -> no IfValid; state IDLE after the ack; the next fetch returns new data.
- Store: MemReq=1, MemWe=1, MemAddr=0x3C, MemWdata=0x1234_5678 -> RamWe=1, RamAddr=15, RamWdata=0x12345678 held until ack; MemValid pulses; MemRdata unchanged.
- Timeout: grant a fetch, hold RamAck=0 -> TimeoutErr=1 exactly 16 busy cycles after RamReq rises and stays set; a late ack still completes with IfValid.
- Reset mid-transaction: reset asserted in BUSY_MEM -> all outputs 0 and state IDLE next cycle; a RamAck arriving afterwards produces no Valid.
